vga_ship_renderer: RTL and testbench
====================================

Name: vga_ship_renderer

Overview:
- Reader end of the ship-position interface: accepts ship_x/ship_y updates from the physics/game logic.
- Generates 640x480@60 VGA timing from the 50 MHz clk and draws the ship as a square sprite.
- Position updates are double-buffered and applied only at vertical-blank start, so no frame tears.
- Sits between the game-state logic and the VGA DAC pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- CLK_DIV, 2, clk cycles per pixel tick
- SHIP_SIZE, 16, sprite edge length in pixels (even)

Ports:
- clk  in  1  50 MHz system clock
- reset  in  1  synchronous, active-high reset
- ship_x  in  16  unsigned ship centre X
- ship_y  in  16  unsigned ship centre Y
- pos_valid  in  1  ship_x/ship_y valid this cycle
- pos_ready  out  1  renderer can accept a new position
- frame_start  out  1  one-clk pulse at vblank start
- VGA_R  out  8  red
- VGA_G  out  8  green
- VGA_B  out  8  blue
- VGA_HS  out  1  horizontal sync, active low
- VGA_VS  out  1  vertical sync, active low
- VGA_BLANK_N  out  1  high during active video

Behaviour:
- Pixel tick: a divider counts 0..CLK_DIV-1 and asserts tick when it reaches CLK_DIV-1. All counters and outputs advance only on tick.
- h_cnt runs 0..H_TOTAL-1, where H_TOTAL = 800. On wrap to 0, v_cnt increments.
- v_cnt runs 0..V_TOTAL-1, where V_TOTAL = 525, and wraps to 0.
- VGA_HS is low for h_cnt in [656, 751]. VGA_VS is low for v_cnt in [490, 491]. VGA_BLANK_N is high for h_cnt < 640 and v_cnt < 480.
- Output latency: sync, blank and RGB are registered. They reflect the counter values from the previous tick, so all three are mutually aligned.
- Handshake: one-entry pending buffer. pos_ready is high when the buffer is empty. A transfer is pos_valid && pos_ready at a clk edge; data is captured and the buffer becomes full. Transfers are evaluated every clk, not only on tick. With pos_ready low, pos_valid is ignored and the producer holds its data.
- Vblank transfer: on the tick where h_cnt == 0 and v_cnt == 480:
  - frame_start pulses for one clk.
  - If the pending buffer was full before this edge, its contents are copied to the active position and the buffer is emptied.
- Simultaneous events: a handshake on the same edge as the vblank copy sees an empty buffer (pos_ready high). It fills the buffer and is displayed next frame; the copy uses only previously held data.
- Sprite hit: (h_cnt - ax) in [-SHIP_SIZE/2, SHIP_SIZE/2-1] and (v_cnt - ay) in the same range. Use 17-bit signed differences with no wrap.
  - Centres near or beyond the screen edge clip naturally.
  - Coordinates >= 640 (X) or >= 480 (Y) plus SHIP_SIZE/2 draw nothing.
- Colour: hit during active video gives 0xFF/0xFF/0xFF; otherwise 0x00/0x00/0x00. RGB is forced to 0 whenever blank.
- Reset values:
  - Divider, h_cnt and v_cnt = 0; active position = (320, 240); pending buffer empty.
  - pos_ready = 1, frame_start = 0, RGB = 0, VGA_HS = 1, VGA_VS = 1, VGA_BLANK_N = 0.
- Reset mid-frame: all of the above apply on the next clk edge. Any pending position is discarded.

Optional Feature:
- Macro CENTER_BODY_EN.
- Defined: a 9x9 yellow square (R=0xFF, G=0xFF, B=0x00) is drawn centred at (320, 240) to mark the gravitational body. Where it overlaps the ship, ship white has priority.
- Undefined: no body is drawn, and none of the marker compare logic exists.

Test Plan:
- Reset, then run 2 frames: HS low 96 ticks per 800; VS low 2 lines per 525; BLANK_N high 640x480 per frame; frame_start period 2*800*525 = 840000 clks.
- After reset with no updates: white pixels exactly at h 312..327, v 232..247; all others black.
- Send (100, 50) with pos_valid mid-frame at v_cnt = 100: pos_ready falls next clk; current frame still draws at (320, 240); next frame draws at h 92..107, v 42..57; pos_ready returns high after the vblank copy.
- Send (5, 5): ship clipped to h 0..12, v 0..12. Send (700, 600): no white pixel in the frame.
- Hold pos_valid with (200, 200) then (300, 300) back-to-back: second is not accepted until ready reasserts; frames show 200 then 300. Handshake on the vblank-start edge is taken and displayed next frame.
- Assert reset at h = 400, v = 300 with a pending update: outputs return to reset values next clk; pending is discarded; ship redraws at (320, 240).

Source files
------------

// File: rtl/vga_ship_renderer.sv
// rtl/vga_ship_renderer.sv - VGA timing generator drawing a double-buffered square ship sprite
// Optional macro CENTER_BODY_EN adds a 9x9 yellow body marker at screen centre.
module vga_ship_renderer #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int CLK_DIV   = 2,
    parameter int SHIP_SIZE = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ship_x,
    input  logic [15:0] ship_y,
    input  logic        pos_valid,
    output logic        pos_ready,
    output logic        frame_start,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_FIRST = H_ACTIVE + H_FP;
    localparam int HS_LAST  = HS_FIRST + H_SYNC - 1;
    localparam int VS_FIRST = V_ACTIVE + V_FP;
    localparam int VS_LAST  = VS_FIRST + V_SYNC - 1;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int H_W      = $clog2(H_TOTAL);
    localparam int V_W      = $clog2(V_TOTAL);

    localparam logic [15:0]        X_HOME = 16'(H_ACTIVE / 2);
    localparam logic [15:0]        Y_HOME = 16'(V_ACTIVE / 2);
    localparam logic signed [16:0] HIT_LO = 17'(-(SHIP_SIZE / 2));
    localparam logic signed [16:0] HIT_HI = 17'(SHIP_SIZE / 2 - 1);

    logic [DIV_W-1:0]   div_cnt;
    logic [H_W-1:0]     h_cnt;
    logic [V_W-1:0]     v_cnt;
    logic               tick;
    logic               vblank_start;
    logic [15:0]        act_x, act_y;
    logic [15:0]        pend_x, pend_y;
    logic               pend_full;
    logic signed [16:0] h_pos, v_pos, dx, dy;
    logic               in_active, hs_on, vs_on, ship_hit;
    logic [7:0]         pix_r, pix_g, pix_b;

    assign tick         = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign vblank_start = tick && (h_cnt == '0) && (v_cnt == V_W'(V_ACTIVE));
    assign pos_ready    = !pend_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            if (tick) begin
                if (h_cnt == H_W'(H_TOTAL - 1)) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_W'(V_TOTAL - 1)) ? '0 : v_cnt + V_W'(1);
                end else begin
                    h_cnt <= h_cnt + H_W'(1);
                end
            end
        end
    end

    // Pending slot only ever fills when empty and only drains when full, so the
    // vblank copy and a new handshake can never target the same data.
    always_ff @(posedge clk) begin
        if (reset) begin
            act_x     <= X_HOME;
            act_y     <= Y_HOME;
            pend_x    <= '0;
            pend_y    <= '0;
            pend_full <= 1'b0;
        end else if (vblank_start && pend_full) begin
            act_x     <= pend_x;
            act_y     <= pend_y;
            pend_full <= 1'b0;
        end else if (pos_valid && !pend_full) begin
            pend_x    <= ship_x;
            pend_y    <= ship_y;
            pend_full <= 1'b1;
        end
    end

    assign h_pos     = $signed({1'b0, 16'(h_cnt)});
    assign v_pos     = $signed({1'b0, 16'(v_cnt)});
    assign dx        = h_pos - $signed({1'b0, act_x});
    assign dy        = v_pos - $signed({1'b0, act_y});
    assign ship_hit  = (dx >= HIT_LO) && (dx <= HIT_HI) && (dy >= HIT_LO) && (dy <= HIT_HI);
    assign in_active = (h_cnt < H_W'(H_ACTIVE)) && (v_cnt < V_W'(V_ACTIVE));
    assign hs_on     = (h_cnt >= H_W'(HS_FIRST)) && (h_cnt <= H_W'(HS_LAST));
    assign vs_on     = (v_cnt >= V_W'(VS_FIRST)) && (v_cnt <= V_W'(VS_LAST));

`ifdef CENTER_BODY_EN
    localparam logic signed [16:0] BODY_X  = 17'(H_ACTIVE / 2);
    localparam logic signed [16:0] BODY_Y  = 17'(V_ACTIVE / 2);
    localparam logic signed [16:0] BODY_LO = -17'sd4;
    localparam logic signed [16:0] BODY_HI = 17'sd4;

    logic signed [16:0] bx, by;
    logic               body_hit;

    assign bx       = h_pos - BODY_X;
    assign by       = v_pos - BODY_Y;
    assign body_hit = (bx >= BODY_LO) && (bx <= BODY_HI) && (by >= BODY_LO) && (by <= BODY_HI);
`endif

    // Ship white wins over the body marker; everything is black outside active video.
    always_comb begin
        pix_r = 8'h00;
        pix_g = 8'h00;
        pix_b = 8'h00;
        if (in_active) begin
            if (ship_hit) begin
                pix_r = 8'hFF;
                pix_g = 8'hFF;
                pix_b = 8'hFF;
            end
`ifdef CENTER_BODY_EN
            else if (body_hit) begin
                pix_r = 8'hFF;
                pix_g = 8'hFF;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            VGA_R       <= 8'h00;
            VGA_G       <= 8'h00;
            VGA_B       <= 8'h00;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= vblank_start;
            if (tick) begin
                VGA_HS      <= !hs_on;
                VGA_VS      <= !vs_on;
                VGA_BLANK_N <= in_active;
                VGA_R       <= pix_r;
                VGA_G       <= pix_g;
                VGA_B       <= pix_b;
            end
        end
    end
endmodule

// File: tb/tb_vga_ship_renderer.sv
// tb/tb_vga_ship_renderer.sv - self-checking bench for vga_ship_renderer on a reduced raster
// A per-clk reference model feeds a scoreboard queue; scenario tasks add targeted checks.
module tb_vga_ship_renderer;
    localparam int H_ACTIVE = 24, H_FP = 2, H_SYNC = 4, H_BP = 2;
    localparam int V_ACTIVE = 16, V_FP = 2, V_SYNC = 2, V_BP = 2;
    localparam int CLK_DIV  = 2;
    localparam int SHIP     = 4;
    localparam int H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME_TICKS = H_TOTAL * V_TOTAL;
    localparam int FRAME_CLKS  = FRAME_TICKS * CLK_DIV;
    localparam int MID         = (V_TOTAL - V_ACTIVE + 4) * H_TOTAL * CLK_DIV;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] ship_x, ship_y;
    logic        pos_valid;
    logic        pos_ready, frame_start;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        VGA_HS, VGA_VS, VGA_BLANK_N;

    int n_checks = 0;
    int n_pass   = 0;

    vga_ship_renderer #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .CLK_DIV(CLK_DIV), .SHIP_SIZE(SHIP)
    ) dut (
        .clk(clk), .reset(reset), .ship_x(ship_x), .ship_y(ship_y),
        .pos_valid(pos_valid), .pos_ready(pos_ready), .frame_start(frame_start),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N)
    );

    always #5 clk = ~clk;

    // Reference model state: m_n counts non-reset clk edges since the last reset.
    int          m_n, m_t, m_h, m_v;
    logic [15:0] m_ax, m_ay, m_px, m_py;
    logic        m_pend, m_tick, m_take, m_fs, m_hs, m_vs, m_bl;
    logic [23:0] m_rgb;
    logic [28:0] exp_q[$];
    logic [28:0] mon_exp, mon_act;

    function automatic logic [23:0] exp_rgb(int h, int v, int ax, int ay);
        if (h >= H_ACTIVE || v >= V_ACTIVE) return 24'h000000;
        if (h >= ax - SHIP / 2 && h < ax + SHIP / 2 && v >= ay - SHIP / 2 && v < ay + SHIP / 2)
            return 24'hFFFFFF;
`ifdef CENTER_BODY_EN
        if (h >= H_ACTIVE / 2 - 4 && h <= H_ACTIVE / 2 + 4 && v >= V_ACTIVE / 2 - 4 && v <= V_ACTIVE / 2 + 4)
            return 24'hFFFF00;
`endif
        return 24'h000000;
    endfunction

    function automatic bit next_tick_at(int h, int v);
        return ((m_n % CLK_DIV) == CLK_DIV - 1) && (((m_n / CLK_DIV) % FRAME_TICKS) == v * H_TOTAL + h);
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_n = 0; m_ax = 16'(H_ACTIVE / 2); m_ay = 16'(V_ACTIVE / 2);
                m_pend = 1'b0; m_rgb = 24'h0; m_hs = 1'b1; m_vs = 1'b1; m_bl = 1'b0; m_fs = 1'b0;
            end else begin
                m_tick = (m_n % CLK_DIV) == CLK_DIV - 1;
                m_t    = (m_n / CLK_DIV) % FRAME_TICKS;
                m_h    = m_t % H_TOTAL;
                m_v    = m_t / H_TOTAL;
                m_fs   = m_tick && m_h == 0 && m_v == V_ACTIVE;
                if (m_tick) begin
                    m_rgb = exp_rgb(m_h, m_v, int'(m_ax), int'(m_ay));
                    m_hs  = !(m_h >= H_ACTIVE + H_FP && m_h < H_ACTIVE + H_FP + H_SYNC);
                    m_vs  = !(m_v >= V_ACTIVE + V_FP && m_v < V_ACTIVE + V_FP + V_SYNC);
                    m_bl  = m_h < H_ACTIVE && m_v < V_ACTIVE;
                end
                m_take = pos_valid && !m_pend;
                if (m_fs && m_pend) begin
                    m_ax = m_px;
                    m_ay = m_py;
                end
                if (m_take) begin
                    m_px = ship_x;
                    m_py = ship_y;
                end
                m_pend = m_take || (m_pend && !m_fs);
                m_n++;
            end
            exp_q.push_back({m_rgb, m_hs, m_vs, m_bl, m_fs, !m_pend});
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                mon_act = {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, frame_start, pos_ready};
                n_checks++;
                if (mon_act !== mon_exp)
                    $display("FAIL scoreboard @%0t: got {rgb,hs,vs,bl,fs,rdy}=%h expected %h", $time, mon_act, mon_exp);
                else
                    n_pass++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_fs();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < FRAME_CLKS + 10; k++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) $display("FAIL wait_fs: got no frame_start expected one within %0d clks", FRAME_CLKS + 10);
        else n_pass++;
    endtask

    // Measures output statistics up to and including the next frame_start clk;
    // optionally offers one position at iteration inj_at.
    task automatic measure_frame(input int inj_at, input int ix, input int iy,
                                 output int white, output int hsl, output int vsl,
                                 output int blk, output int clks, output logic rdy_after);
        white = 0; hsl = 0; vsl = 0; blk = 0; clks = 0; rdy_after = 1'bx;
        for (int k = 0; k < FRAME_CLKS + 10; k++) begin
            if (k == inj_at) begin
                pos_valid = 1'b1;
                ship_x    = 16'(ix);
                ship_y    = 16'(iy);
            end
            @(negedge clk);
            if (k == inj_at) begin
                pos_valid = 1'b0;
                rdy_after = pos_ready;
            end
            clks++;
            if ({VGA_R, VGA_G, VGA_B} === 24'hFFFFFF) white++;
            if (VGA_HS === 1'b0) hsl++;
            if (VGA_VS === 1'b0) vsl++;
            if (VGA_BLANK_N === 1'b1) blk++;
            if (frame_start === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({VGA_R, VGA_G, VGA_B} !== 24'h0) $display("FAIL reset_rgb: got %h expected 000000", {VGA_R, VGA_G, VGA_B});
        else n_pass++;
        n_checks++;
        if ({VGA_HS, VGA_VS, VGA_BLANK_N} !== 3'b110) $display("FAIL reset_sync: got %b expected 110", {VGA_HS, VGA_VS, VGA_BLANK_N});
        else n_pass++;
        n_checks++;
        if ({frame_start, pos_ready} !== 2'b01) $display("FAIL reset_hs: got fs,rdy=%b expected 01", {frame_start, pos_ready});
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_timing();
        int white, hsl, vsl, blk, clks;
        logic rdy;
        wait_fs();
        for (int f = 0; f < 2; f++) begin
            measure_frame(-1, 0, 0, white, hsl, vsl, blk, clks, rdy);
            n_checks++;
            if (clks !== FRAME_CLKS) $display("FAIL frame_period: got %0d expected %0d", clks, FRAME_CLKS);
            else n_pass++;
            n_checks++;
            if (hsl !== H_SYNC * V_TOTAL * CLK_DIV) $display("FAIL hs_low: got %0d expected %0d", hsl, H_SYNC * V_TOTAL * CLK_DIV);
            else n_pass++;
            n_checks++;
            if (vsl !== V_SYNC * H_TOTAL * CLK_DIV) $display("FAIL vs_low: got %0d expected %0d", vsl, V_SYNC * H_TOTAL * CLK_DIV);
            else n_pass++;
            n_checks++;
            if (blk !== H_ACTIVE * V_ACTIVE * CLK_DIV) $display("FAIL blank_n_high: got %0d expected %0d", blk, H_ACTIVE * V_ACTIVE * CLK_DIV);
            else n_pass++;
            n_checks++;
            if (white !== SHIP * SHIP * CLK_DIV) $display("FAIL home_white: got %0d expected %0d", white, SHIP * SHIP * CLK_DIV);
            else n_pass++;
        end
    endtask

    task automatic test_update();
        int white, hsl, vsl, blk, clks;
        logic rdy;
        wait_fs();
        measure_frame(MID, 5, 4, white, hsl, vsl, blk, clks, rdy);
        n_checks++;
        if (rdy !== 1'b0) $display("FAIL update_ready_fall: got %b expected 0", rdy);
        else n_pass++;
        n_checks++;
        if (pos_ready !== 1'b1) $display("FAIL update_ready_back: got %b expected 1", pos_ready);
        else n_pass++;
        measure_frame(-1, 0, 0, white, hsl, vsl, blk, clks, rdy);
        n_checks++;
        if (white !== SHIP * SHIP * CLK_DIV) $display("FAIL update_new_white: got %0d expected %0d", white, SHIP * SHIP * CLK_DIV);
        else n_pass++;
    endtask

    task automatic test_clip();
        int xs[3]  = '{1, 26, 25};
        int ys[3]  = '{1, 18, 17};
        int pix[3] = '{9, 0, 1};
        int white, hsl, vsl, blk, clks;
        logic rdy;
        wait_fs();
        measure_frame(0, xs[0], ys[0], white, hsl, vsl, blk, clks, rdy);
        for (int i = 0; i < 3; i++) begin
            if (i < 2) measure_frame(0, xs[i + 1], ys[i + 1], white, hsl, vsl, blk, clks, rdy);
            else       measure_frame(-1, 0, 0, white, hsl, vsl, blk, clks, rdy);
            n_checks++;
            if (white !== pix[i] * CLK_DIV)
                $display("FAIL clip_white_%0d_%0d: got %0d expected %0d", xs[i], ys[i], white, pix[i] * CLK_DIV);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int white, hsl, vsl, blk, clks;
        logic rdy;
        bit got;
        wait_fs();
        pos_valid = 1'b1; ship_x = 16'd1; ship_y = 16'd10;
        @(negedge clk);
        n_checks++;
        if (pos_ready !== 1'b0) $display("FAIL b2b_first_taken: got %b expected 0", pos_ready);
        else n_pass++;
        ship_x = 16'd18; ship_y = 16'd11;
        got = 1'b0;
        for (int k = 0; k < FRAME_CLKS + 10; k++) begin
            @(negedge clk);
            if (pos_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!got || frame_start !== 1'b1) $display("FAIL b2b_ready_at_vblank: got ready=%b fs=%b expected 1 1", got, frame_start);
        else n_pass++;
        @(negedge clk);
        pos_valid = 1'b0;
        n_checks++;
        if (pos_ready !== 1'b0) $display("FAIL b2b_second_taken: got %b expected 0", pos_ready);
        else n_pass++;
        measure_frame(-1, 0, 0, white, hsl, vsl, blk, clks, rdy);
        n_checks++;
        if (white !== 12 * CLK_DIV) $display("FAIL b2b_first_frame: got %0d expected %0d", white, 12 * CLK_DIV);
        else n_pass++;
        measure_frame(FRAME_CLKS - 1, 0, 0, white, hsl, vsl, blk, clks, rdy);
        n_checks++;
        if (rdy !== 1'b0) $display("FAIL vblank_edge_taken: got %b expected 0", rdy);
        else n_pass++;
        n_checks++;
        if (white !== 16 * CLK_DIV) $display("FAIL b2b_second_frame: got %0d expected %0d", white, 16 * CLK_DIV);
        else n_pass++;
        measure_frame(-1, 0, 0, white, hsl, vsl, blk, clks, rdy);
        n_checks++;
        if (white !== 16 * CLK_DIV) $display("FAIL vblank_edge_deferred: got %0d expected %0d", white, 16 * CLK_DIV);
        else n_pass++;
        measure_frame(-1, 0, 0, white, hsl, vsl, blk, clks, rdy);
        n_checks++;
        if (white !== 4 * CLK_DIV) $display("FAIL vblank_edge_shown: got %0d expected %0d", white, 4 * CLK_DIV);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int white, hsl, vsl, blk, clks;
        logic rdy;
        bit found;
        wait_fs();
        pos_valid = 1'b1; ship_x = 16'd1; ship_y = 16'd1;
        @(negedge clk);
        pos_valid = 1'b0;
        n_checks++;
        if (pos_ready !== 1'b0) $display("FAIL rst_pending_full: got %b expected 0", pos_ready);
        else n_pass++;
        found = 1'b0;
        for (int k = 0; k < FRAME_CLKS + 10; k++) begin
            if (next_tick_at(12, 10)) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (!found) $display("FAIL rst_point: got no tick at (12,10) expected one");
        else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N} !== {24'h0, 3'b110})
            $display("FAIL rst_mid_outputs: got %h expected %h", {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N}, {24'h0, 3'b110});
        else n_pass++;
        n_checks++;
        if ({frame_start, pos_ready} !== 2'b01) $display("FAIL rst_mid_hs: got fs,rdy=%b expected 01", {frame_start, pos_ready});
        else n_pass++;
        reset = 1'b0;
        wait_fs();
        measure_frame(-1, 0, 0, white, hsl, vsl, blk, clks, rdy);
        n_checks++;
        if (white !== SHIP * SHIP * CLK_DIV) $display("FAIL rst_home_sprite: got %0d expected %0d", white, SHIP * SHIP * CLK_DIV);
        else n_pass++;
    endtask

    initial begin
        reset = 1'b1; pos_valid = 1'b0; ship_x = 16'd0; ship_y = 16'd0;
        test_reset();
        test_timing();
        test_update();
        test_clip();
        test_back_to_back();
        test_reset_mid();
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
